// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: paces AD4008 conversion starts and buffers returned samples in a small FIFO.
module adc_sample_scheduler #(
    parameter int unsigned ADC_WIDTH      = 16,
    parameter int unsigned PERIOD_WIDTH   = 16,
    parameter int unsigned BURST_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             aresetn,
    input  logic                             enable,
    input  logic [PERIOD_WIDTH-1:0]          period,
    input  logic [BURST_WIDTH-1:0]           burst_len,
    input  logic                             clr_err,
    output logic                             adc_start,
    input  logic                             adc_new_data,
    input  logic [ADC_WIDTH-1:0]             adc_data,
    output logic [ADC_WIDTH-1:0]             m_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             busy,
    output logic                             burst_done,
    output logic                             timeout_err,
    output logic                             overflow_err
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DATA = 2'd2,
        HOLDOFF   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    enable_q;
    logic [PERIOD_WIDTH-1:0] period_cnt_q, period_cnt_d;
    logic [TO_W-1:0]         timeout_cnt_q, timeout_cnt_d;
    logic [BURST_WIDTH-1:0]  sample_cnt_q, sample_cnt_d;
    logic [BURST_WIDTH-1:0]  burst_len_q, burst_len_d;
    logic                    adc_start_d, busy_d, burst_done_d;

    logic [ADC_WIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_d;
    logic [ADC_WIDTH-1:0]    m_data_d;
    logic                    m_valid_d;
    logic                    timeout_err_d, overflow_err_d;

    logic                    arm_c, tmo_hit_c, holdoff_exit_c, burst_hit_c;
    logic                    push_req, tmo_evt;
    logic                    pop_c, full_c, push_ok_c, ovf_evt_c;
    logic [PERIOD_WIDTH-1:0] period_load_c, period_dec_c;

    assign arm_c          = enable && !enable_q;
    assign tmo_hit_c      = (timeout_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) && !adc_new_data;
    // Exit on the cycle the counter reaches zero so start-to-start spacing equals the period.
    assign holdoff_exit_c = (state_q == HOLDOFF) && (period_cnt_q <= PERIOD_WIDTH'(1));
    assign burst_hit_c    = (burst_len_q != '0) && (sample_cnt_q == burst_len_q);
    assign period_load_c  = (period < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(1)
                                                        : period - PERIOD_WIDTH'(1);
    assign period_dec_c   = (period_cnt_q == '0) ? '0 : period_cnt_q - PERIOD_WIDTH'(1);

    // State register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (arm_c) state_d = START;
            START:     state_d = WAIT_DATA;
            WAIT_DATA: if (adc_new_data || tmo_hit_c) state_d = HOLDOFF;
            HOLDOFF: begin
                if (holdoff_exit_c) begin
                    if (burst_hit_c || !enable) state_d = IDLE;
                    else                        state_d = START;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    // Output and counter next-values for the sequencer
    always_comb begin
        period_cnt_d  = period_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        sample_cnt_d  = sample_cnt_q;
        burst_len_d   = burst_len_q;
        push_req      = 1'b0;
        tmo_evt       = 1'b0;
        adc_start_d   = (state_d == START);
        busy_d        = (state_d != IDLE);
        burst_done_d  = holdoff_exit_c && burst_hit_c;
        unique case (state_q)
            IDLE: begin
                if (arm_c) sample_cnt_d = '0;
            end
            START: begin
                period_cnt_d  = period_load_c;
                timeout_cnt_d = '0;
                sample_cnt_d  = sample_cnt_q + BURST_WIDTH'(1);
                burst_len_d   = burst_len;
            end
            WAIT_DATA: begin
                period_cnt_d  = period_dec_c;
                timeout_cnt_d = timeout_cnt_q + TO_W'(1);
                push_req      = adc_new_data;
                tmo_evt       = tmo_hit_c;
            end
            HOLDOFF: begin
                period_cnt_d  = period_dec_c;
            end
            default: ;
        endcase
    end

    // FIFO bookkeeping; head is re-registered so m_data tracks the post-update read pointer
    always_comb begin
        pop_c     = m_valid && m_ready;
        full_c    = (fifo_level == LVL_W'(FIFO_DEPTH));
        push_ok_c = push_req && (!full_c || pop_c);
        ovf_evt_c = push_req && full_c && !pop_c;
        wr_ptr_d  = push_ok_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d   = fifo_level;
        if (push_ok_c && !pop_c)      level_d = fifo_level + LVL_W'(1);
        else if (!push_ok_c && pop_c) level_d = fifo_level - LVL_W'(1);
        m_valid_d = (level_d != '0);
        m_data_d  = m_data;
        if (level_d != '0) begin
            if (push_ok_c && (rd_ptr_d == wr_ptr_q)) m_data_d = adc_data;
            else                                     m_data_d = mem_q[rd_ptr_d];
        end
    end

    // Sticky errors: a new event wins over a simultaneous clear
    always_comb begin
        timeout_err_d  = (timeout_err  && !clr_err) || tmo_evt;
        overflow_err_d = (overflow_err && !clr_err) || ovf_evt_c;
    end

    // Sequencer, FIFO control and output registers
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            enable_q      <= 1'b0;
            period_cnt_q  <= '0;
            timeout_cnt_q <= '0;
            sample_cnt_q  <= '0;
            burst_len_q   <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_level    <= '0;
            m_data        <= '0;
            m_valid       <= 1'b0;
            adc_start     <= 1'b0;
            busy          <= 1'b0;
            burst_done    <= 1'b0;
            timeout_err   <= 1'b0;
            overflow_err  <= 1'b0;
        end else begin
            enable_q      <= enable;
            period_cnt_q  <= period_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            sample_cnt_q  <= sample_cnt_d;
            burst_len_q   <= burst_len_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_level    <= level_d;
            m_data        <= m_data_d;
            m_valid       <= m_valid_d;
            adc_start     <= adc_start_d;
            busy          <= busy_d;
            burst_done    <= burst_done_d;
            timeout_err   <= timeout_err_d;
            overflow_err  <= overflow_err_d;
        end
    end

    // Sample storage (no reset needed; validity is tracked by the pointers)
    always_ff @(posedge clk) begin
        if (push_ok_c) mem_q[wr_ptr_q] <= adc_data;
    end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Testbench for adc_sample_scheduler: table-driven burst vectors plus hand-written corner sequences.
module tb_adc_sample_scheduler;

    localparam int unsigned ADC_W = 16;
    localparam int unsigned PER_W = 16;
    localparam int unsigned BUR_W = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 64;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             aresetn = 1'b0;
    logic             enable = 1'b0;
    logic [PER_W-1:0] period = '0;
    logic [BUR_W-1:0] burst_len = '0;
    logic             clr_err = 1'b0;
    logic             adc_start;
    logic             adc_new_data = 1'b0;
    logic [ADC_W-1:0] adc_data = '0;
    logic [ADC_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [LVL_W-1:0] fifo_level;
    logic             busy;
    logic             burst_done;
    logic             timeout_err;
    logic             overflow_err;

    adc_sample_scheduler #(
        .ADC_WIDTH(ADC_W), .PERIOD_WIDTH(PER_W), .BURST_WIDTH(BUR_W),
        .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .aresetn(aresetn), .enable(enable), .period(period),
        .burst_len(burst_len), .clr_err(clr_err), .adc_start(adc_start),
        .adc_new_data(adc_new_data), .adc_data(adc_data), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level),
        .busy(busy), .burst_done(burst_done), .timeout_err(timeout_err),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Environment controls (written by the main sequence only)
    int emu_on = 0;
    int emu_delay = 4;
    int sb_on = 0;
    int rdy_mode = 0;     // 0: never ready, 1: always ready, 2: ready only with returned data
    int inj_cycle = -1;

    // Environment state (written by the environment process only)
    logic [ADC_W-1:0] emu_val = 16'hA000;
    logic [ADC_W-1:0] exp_q[$];
    int starts_q[$];
    int bd_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_neg(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_clr();
        tick(1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    // ADC reader emulator on the rising side, observer/scoreboard on the falling side
    initial begin : env
        int cd;
        cd = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            adc_new_data = 1'b0;
            m_ready = (rdy_mode == 1);
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    adc_new_data = 1'b1;
                    adc_data = emu_val;
                    if (sb_on != 0) exp_q.push_back(emu_val);
                    emu_val = emu_val + 16'd1;
                    if (rdy_mode == 2) m_ready = 1'b1;
                end
            end
            if (cyc == inj_cycle) begin
                adc_new_data = 1'b1;
                adc_data = 16'hDEAD;
            end
            if (adc_start && emu_on != 0) cd = emu_delay;
            @(negedge clk);
            if (adc_start) starts_q.push_back(cyc);
            if (burst_done) bd_q.push_back(cyc);
            if (sb_on != 0 && m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("unexpected_pop", 32'(m_data), 32'hFFFF_FFFF);
                else chk("m_data_order", 32'(m_data), 32'(exp_q.pop_front()));
            end
        end
    end

    typedef struct {
        logic [PER_W-1:0] period;
        logic [BUR_W-1:0] burst;
        int               delay;
        int               exp_sp;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int arm, s0, b0, ns, nb, max_lvl, a;
        logic [ADC_W-1:0] base;
        logic [ADC_W-1:0] drain[8];

        vecs[0] = '{16'd10, 8'd3, 4, 10};
        vecs[1] = '{16'd8,  8'd3, 4, 8};
        vecs[2] = '{16'd0,  8'd3, 1, 3};
        vecs[3] = '{16'd1,  8'd2, 1, 3};
        vecs[4] = '{16'd0,  8'd2, 3, 5};
        vecs[5] = '{16'd5,  8'd2, 6, 8};
        vecs[6] = '{16'd6,  8'd1, 4, 6};
        vecs[7] = '{16'd4,  8'd4, 2, 4};
        vecs[8] = '{16'd4,  8'd2, 3, 5};
        vecs[9] = '{16'd3,  8'd3, 1, 3};

        // Reset state
        tick(3);
        chk("rst_adc_start", 32'(adc_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_errs", 32'({timeout_err, overflow_err, burst_done}), 0);
        aresetn = 1'b1;
        tick(3);

        // Burst vectors: count, spacing, arm latency, burst_done timing, no re-arm while held
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            emu_delay = vecs[i].delay;
            emu_on = 1;
            sb_on = 1;
            rdy_mode = 1;
            tick(1);
            period = vecs[i].period;
            burst_len = vecs[i].burst;
            enable = 1'b1;
            arm = cyc;
            s0 = starts_q.size();
            b0 = bd_q.size();
            for (int k = 0; k < 600 && bd_q.size() == b0; k++) tick(1);
            tick(30);
            ns = starts_q.size() - s0;
            nb = bd_q.size() - b0;
            chk("burst_done_count", 32'(nb), 1);
            chk("start_count", 32'(ns), 32'(vecs[i].burst));
            if (ns > 0) begin
                chk("arm_latency", 32'(starts_q[s0] - arm), 1);
                if (nb == 1) chk("burst_done_cycle", 32'(bd_q[b0] - starts_q[s0+ns-1]), 32'(vecs[i].exp_sp));
            end
            for (int j = 1; j < ns; j++)
                chk("start_spacing", 32'(starts_q[s0+j] - starts_q[s0+j-1]), 32'(vecs[i].exp_sp));
            chk("samples_drained", 32'(exp_q.size()), 0);
            chk("busy_after_burst", 32'(busy), 0);
            chk("no_errors", 32'({timeout_err, overflow_err}), 0);
            enable = 1'b0;
            tick(2);
        end

        // Continuous mode, then enable dropped during WAIT_DATA
        @(negedge clk);
        emu_delay = 4;
        tick(1);
        period = 16'd10;
        burst_len = 8'd0;
        enable = 1'b1;
        arm = cyc;
        s0 = starts_q.size();
        max_lvl = 0;
        for (int k = 0; k < 52; k++) begin
            @(negedge clk);
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        end
        @(posedge clk);
        #1;
        enable = 1'b0;
        chk("wait_state_busy", 32'(busy), 1);
        tick(30);
        ns = starts_q.size() - s0;
        chk("cont_start_count", 32'(ns), 6);
        for (int j = 1; j < ns; j++)
            chk("cont_spacing", 32'(starts_q[s0+j] - starts_q[s0+j-1]), 10);
        chk("cont_max_level", 32'(max_lvl), 1);
        chk("cont_drained", 32'(exp_q.size()), 0);
        chk("cont_busy_off", 32'(busy), 0);

        // Overflow: nine samples into an eight-entry FIFO with no consumer
        @(negedge clk);
        sb_on = 0;
        rdy_mode = 0;
        emu_delay = 2;
        base = emu_val;
        tick(1);
        period = 16'd4;
        burst_len = 8'd9;
        enable = 1'b1;
        b0 = bd_q.size();
        for (int k = 0; k < 600 && bd_q.size() == b0; k++) tick(1);
        tick(3);
        enable = 1'b0;
        chk("ovf_level", 32'(fifo_level), 8);
        chk("ovf_flag", 32'(overflow_err), 1);
        chk("ovf_head", 32'(m_data), 32'(base));
        pulse_clr();
        chk("ovf_cleared", 32'(overflow_err), 0);
        chk("ovf_level_kept", 32'(fifo_level), 8);
        // Push and pop together while full
        @(negedge clk);
        rdy_mode = 2;
        tick(1);
        burst_len = 8'd1;
        enable = 1'b1;
        b0 = bd_q.size();
        for (int k = 0; k < 600 && bd_q.size() == b0; k++) tick(1);
        tick(2);
        enable = 1'b0;
        chk("full_pushpop_level", 32'(fifo_level), 8);
        chk("full_pushpop_noerr", 32'(overflow_err), 0);
        for (int j = 0; j < 7; j++) drain[j] = base + 16'(j + 1);
        drain[7] = base + 16'd9;
        @(negedge clk);
        rdy_mode = 1;
        @(posedge clk);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("drain_data", 32'({m_valid, m_data}), 32'({1'b1, drain[j]}));
        end
        @(negedge clk);
        chk("drain_empty", 32'({m_valid, fifo_level}), 0);

        // Timeout: no data returned, late data ignored, next start still issued
        emu_on = 0;
        tick(1);
        period = 16'd10;
        burst_len = 8'd2;
        enable = 1'b1;
        a = cyc;
        s0 = starts_q.size();
        b0 = bd_q.size();
        wait_neg(a + 61);
        chk("tmo_not_yet", 32'(timeout_err), 0);
        inj_cycle = a + 66;
        wait_neg(a + 67);
        chk("tmo_set", 32'(timeout_err), 1);
        chk("tmo_second_start", 32'(adc_start), 1);
        chk("tmo_late_ignored", 32'(fifo_level), 0);
        for (int k = 0; k < 600 && bd_q.size() == b0; k++) tick(1);
        tick(2);
        enable = 1'b0;
        ns = starts_q.size() - s0;
        chk("tmo_start_count", 32'(ns), 2);
        if (ns == 2) chk("tmo_spacing", 32'(starts_q[s0+1] - starts_q[s0]), 66);
        chk("tmo_no_push", 32'({m_valid, fifo_level}), 0);
        pulse_clr();
        chk("tmo_cleared", 32'(timeout_err), 0);
        inj_cycle = cyc + 2;
        tick(4);
        chk("idle_data_ignored", 32'({m_valid, fifo_level}), 0);

        // Asynchronous reset during WAIT_DATA with a sample buffered
        @(negedge clk);
        emu_on = 1;
        emu_delay = 2;
        rdy_mode = 0;
        tick(1);
        period = 16'd4;
        burst_len = 8'd0;
        enable = 1'b1;
        a = cyc;
        wait_neg(a + 7);
        chk("pre_rst_level", 32'(fifo_level), 1);
        chk("pre_rst_busy", 32'(busy), 1);
        aresetn = 1'b0;
        enable = 1'b0;
        #1;
        chk("async_rst_outputs", 32'({adc_start, m_valid, busy, burst_done, timeout_err, overflow_err}), 0);
        chk("async_rst_level", 32'(fifo_level), 0);
        chk("async_rst_data", 32'(m_data), 0);
        tick(2);
        aresetn = 1'b1;
        s0 = starts_q.size();
        inj_cycle = cyc + 1;
        tick(4);
        chk("post_rst_late_data", 32'({m_valid, fifo_level}), 0);
        chk("post_rst_idle", 32'({busy, starts_q.size() - s0 != 0}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
